// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the decimating FIR engine.
package fir_pkg;

    localparam int unsigned NTAPS  = 32;
    localparam int unsigned DECIM  = 16;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned SMP_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        WRITE,
        FINISH
    } state_t;

endpackage

// File: rtl/fir_coef_rom.sv
// Coefficient ROM with synchronous read and one cycle of latency.
// Contents are c[i] = i + 1.
module fir_coef_rom
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = fir_pkg::NTAPS,
    parameter int unsigned IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                     clk,
    input  logic [IDX_W-1:0]         idx,
    output logic signed [COEF_W-1:0] coef
);

    typedef logic [NTAPS-1:0][COEF_W-1:0] table_t;

    function automatic table_t build_table();
        table_t t;
        for (int j = 0; j < int'(NTAPS); j++) begin
            t[j] = COEF_W'(j + 1);
        end
        return t;
    endfunction

    localparam table_t TABLE = build_table();

    always_ff @(posedge clk) begin
        coef <= $signed(TABLE[idx]);
    end

endmodule

// File: rtl/fir_decim_engine.sv
// Decimating FIR: reads samples from the sample RAM, runs an NTAPS-tap MAC per
// output and writes one ACC_W-bit result per DECIM input samples.
module fir_decim_engine
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS  = fir_pkg::NTAPS,
    parameter int unsigned DECIM  = fir_pkg::DECIM,
    parameter int unsigned SMP_AW = 14,
    parameter int unsigned RES_AW = 10,
    parameter int unsigned ACC_W  = fir_pkg::ACC_W
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [SMP_AW-1:0]       NUM_SAMPLES,
    output logic                    smp_rd_en,
    output logic [SMP_AW-1:0]       smp_rd_address,
    input  logic signed [15:0]      smp_rd_data,
    output logic                    res_wr_en,
    output logic [RES_AW-1:0]       res_wr_address,
    output logic signed [ACC_W-1:0] res_wr_data,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned TAP_W    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int unsigned NOUT_W   = RES_AW + 1;
    localparam int unsigned NOUT_MAX = 1 << RES_AW;
    localparam int unsigned PROD_W   = 2 * SMP_W;

    state_t              state_q, state_d;
    logic [NOUT_W-1:0]   nout_q, nout_d, nout_sat;
    logic [SMP_AW-1:0]   nout_raw;
    logic [RES_AW-1:0]   k_q, k_d;
    logic [SMP_AW-1:0]   n_q, n_d;
    logic [TAP_W-1:0]    i_q, i_d;
    logic                drain_q, drain_d;
    logic                last_k;

    logic [SMP_AW:0]     tap_diff;
    logic                tap_masked;
    logic [SMP_AW-1:0]   addr_hold_q;

    logic                vld1_q, zero1_q, vld2_q;
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic signed [ACC_W-1:0]  acc_q;

    fir_coef_rom #(
        .NTAPS (NTAPS),
        .IDX_W (TAP_W)
    ) u_coef_rom (
        .clk  (CLOCK_50),
        .idx  (i_q),
        .coef (coef)
    );

    // Output count, saturated so the last address never wraps.
    always_comb begin
        nout_raw = NUM_SAMPLES / SMP_AW'(DECIM);
        if (32'(nout_raw) > NOUT_MAX) begin
            nout_sat = NOUT_W'(NOUT_MAX);
        end else begin
            nout_sat = NOUT_W'(nout_raw);
        end
    end

    // A negative tap address means x[j] with j < 0: no read, feed zero.
    assign tap_diff   = {1'b0, n_q} - (SMP_AW+1)'(i_q);
    assign tap_masked = tap_diff[SMP_AW];
    assign last_k     = ({1'b0, k_q} + NOUT_W'(1)) == nout_q;

    assign smp_rd_en      = (state_q == MAC) && !tap_masked;
    assign smp_rd_address = smp_rd_en ? tap_diff[SMP_AW-1:0] : addr_hold_q;

    assign BUSY = (state_q == CLEAR) || (state_q == MAC) ||
                  (state_q == DRAIN) || (state_q == WRITE);
    assign DONE = (state_q == FINISH);

    always_comb begin
        state_d = state_q;
        nout_d  = nout_q;
        k_d     = k_q;
        n_d     = n_q;
        i_d     = i_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    nout_d  = nout_sat;
                    k_d     = '0;
                    n_d     = SMP_AW'(DECIM - 1);
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                i_d     = '0;
                drain_d = 1'b0;
                state_d = (nout_q == '0) ? FINISH : MAC;
            end
            MAC: begin
                i_d = i_q + TAP_W'(1);
                if (i_q == TAP_W'(NTAPS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_k) begin
                    state_d = FINISH;
                end else begin
                    k_d     = k_q + RES_AW'(1);
                    n_d     = n_q + SMP_AW'(DECIM);
                    state_d = CLEAR;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            nout_q  <= '0;
            k_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nout_q  <= nout_d;
            k_q     <= k_d;
            n_q     <= n_d;
            i_q     <= i_d;
            drain_q <= drain_d;
        end
    end

    assign prod_d = smp_rd_data * coef;

    // Tap pipeline: issue -> data/coef -> product -> accumulate.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            addr_hold_q <= '0;
            vld1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            vld2_q      <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
        end else begin
            if (smp_rd_en) begin
                addr_hold_q <= tap_diff[SMP_AW-1:0];
            end
            vld1_q  <= (state_q == MAC);
            zero1_q <= tap_masked;
            vld2_q  <= vld1_q;
            if (vld1_q) begin
                prod_q <= zero1_q ? '0 : prod_d;
            end
            if (state_q == CLEAR) begin
                acc_q <= '0;
            end else if (vld2_q) begin
                acc_q <= acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            res_wr_en      <= 1'b0;
            res_wr_address <= '0;
            res_wr_data    <= '0;
        end else begin
            res_wr_en <= (state_q == WRITE);
            if (state_q == WRITE) begin
                res_wr_address <= k_q;
                res_wr_data    <= acc_q;
            end
        end
    end

endmodule

// File: doc/fir_decim_engine.md
Name: fir_decim_engine

Overview:
- Filter core between the UART receive path and the UART transmit path.
- Reads signed 16-bit samples from the sample RAM, which UART RX writes at 14-bit addresses.
- Runs a 32-tap FIR with decimation by 16, accumulating at 40 bits.
- Writes each 40-bit result to the result RAM, which the UART TX path reads at 10-bit addresses and sends as 5 bytes, LSB first.

Parameters:
- NTAPS, 32, number of FIR taps. Power of two, ≤ DECIM*64.
- DECIM, 16, decimation factor: one output per DECIM input samples.
- SMP_AW, 14, sample RAM address width.
- RES_AW, 10, result RAM address width.
- ACC_W, 40, accumulator and result width.

Ports:
- CLOCK_50 in 1: system clock.
- RESET in 1: asynchronous, active-high reset.
- START in 1: one-cycle pulse; starts a run. Ignored while BUSY.
- NUM_SAMPLES in SMP_AW: number of valid samples. Latched on START.
- smp_rd_en out 1: sample RAM read strobe.
- smp_rd_address out SMP_AW: sample RAM read address.
- smp_rd_data in 16: signed sample. Valid exactly 1 cycle after smp_rd_en.
- res_wr_en out 1: result RAM write strobe, one cycle wide.
- res_wr_address out RES_AW: result RAM write address.
- res_wr_data out ACC_W: signed result.
- BUSY out 1: high from the cycle after START until the cycle after the last write.
- DONE out 1: one-cycle pulse when a run finishes.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator 0, output index 0.
- Output count: NOUT = floor(NUM_SAMPLES / DECIM), saturated to 2^RES_AW.
  - NOUT = 0 gives BUSY for 1 cycle, then DONE, with no writes.
- Function: y[k] = sum over i = 0..NTAPS-1 of c[i] * x[n-i], where n = k*DECIM + DECIM - 1.
  - x[j] = 0 for j < 0. The engine suppresses the read and feeds 0.
- Arithmetic:
  - 16x16 signed multiply gives 32 bits, sign-extended to ACC_W before accumulating.
  - No saturation; wraps modulo 2^ACC_W, which cannot overflow for NTAPS ≤ 256.
- FSM states:
  - IDLE: on START, latch NOUT, set k = 0 → CLEAR.
  - CLEAR: acc = 0, i = 0 → MAC.
  - MAC: each cycle issue the read for tap i with address n-i; i increments.
    - After i = NTAPS-1 has been issued → DRAIN.
  - DRAIN: 2 cycles to flush the pipeline → WRITE.
  - WRITE: assert res_wr_en with address k and data acc.
    - If k == NOUT-1 → FINISH; else k++ → CLEAR.
  - FINISH: DONE = 1, BUSY = 0 → IDLE.
- Pipeline per tap:
  - Cycle t: address and coefficient index.
  - Cycle t+1: data returns and coefficient ROM output is registered.
  - Cycle t+2: product registered.
  - Cycle t+3: accumulate.
  - The zero-fill flag travels with the tap so masked taps add 0.
- Latency: START to first res_wr_en = 1 + 1 + NTAPS + 2 + 1 = 37 cycles at defaults. Per output: 1 + NTAPS + 3 cycles = 36.
- smp_rd_address is held at its last value when smp_rd_en = 0.
- START during BUSY is ignored. The NUM_SAMPLES latch is unchanged.
- RESET mid-run aborts immediately: no further writes and no DONE. Result RAM contents are undefined for the aborted run.
- A run that ends exactly at NOUT = 2^RES_AW wraps to address 0 only if NOUT is over-requested. Saturation prevents this, so the last address is 2^RES_AW - 1.

Decomposition:
- Shared package fir_pkg:
  - NTAPS, DECIM, ACC_W constants.
  - FSM state enum: IDLE, CLEAR, MAC, DRAIN, WRITE, FINISH.
  - Coefficient word width, 16 bits signed.
- One sub-module, fir_coef_rom: synchronous read, 1-cycle latency, NTAPS x 16 signed, init c[i] = i+1 for the bench build.

Test Plan:
- Impulse: x[0] = 1, all other x = 0, NUM_SAMPLES = 64 → 4 writes: addr 0 = 16, addr 1 = 32, addr 2 = 0, addr 3 = 0; then DONE.
- Positive full-scale: all x = 0x7FFF, NUM_SAMPLES = 48 → addr 0 = 32767*136 = 4456312; addr 1 and addr 2 = 17300976.
- Negative full-scale: all x = 0x8000, NUM_SAMPLES = 32 → addr 1 = 0xFFFEF80000 (−17301504).
- Short run: NUM_SAMPLES = 15 → no res_wr_en, DONE one cycle after BUSY rises; a second START 5 cycles later is accepted.
- Timing and protocol: START pulsed, then START re-pulsed at cycle 10 → first write at cycle 37 exactly, re-pulse ignored, write spacing 36 cycles.
- Reset mid-run: assert RESET between the 2nd and 3rd write → all outputs 0 on the same edge, no further writes; a new START runs normally.
